alu_wb_stage: RTL and testbench

Execute/writeback stage directly downstream of the 4-entry, 32-bit register file. Per accepted instruction it:
- drives the regfile read addresses,
- captures both operands,
- computes a result (single-cycle ALU or iterative 32-cycle multiply),
- drives WriteData/WriteReg/RegWrite back into the regfile for exactly one cycle.

One instruction in flight at a time; valid/ready issue handshake on the upstream side.

---
 rtl/alu_wb_stage.sv | 152 +++++++++++++++
 tb/tb_alu_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage for the 4-entry regfile: operand read, ALU or shift-add multiply, one-cycle write strobe.
// Define ALU_MUL_EN to build op 110 as the 32-iteration multiply; otherwise op 110 retires as a NOP.
module alu_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        op,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] ReadReg1,
   output logic [REG_AW-1:0] ReadReg2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData,
   output logic [REG_AW-1:0] WriteReg,
   output logic              RegWrite,
   output logic              busy,
   output logic              zero
);
   localparam int SH_W = $clog2(DATA_W);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

`ifdef ALU_MUL_EN
   typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;
`else
   typedef enum logic [2:0] {IDLE, READ, EXEC, WB} state_t;
`endif

   state_t            state, next_state;
   logic [2:0]        op_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] a, b, res;
   logic              wr_en;

`ifdef ALU_MUL_EN
   localparam logic [5:0] LAST = 6'(DATA_W - 1);
   logic [DATA_W-1:0] acc, acc_sum;
   logic [5:0]        cnt;

   assign acc_sum = acc + (b[0] ? a : '0);
   assign wr_en   = (op_q != OP_NOP);
`else
   assign wr_en   = (op_q != OP_NOP) && (op_q != OP_MUL);
`endif

   always_comb begin
      res = '0;
      case (op_q)
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_SLT:  res[0] = $signed(a) < $signed(b);
         OP_SLL:  res = a << b[SH_W-1:0];
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      busy        = (state != IDLE);
      issue_ready = (state == IDLE);
      case (state)
         IDLE: if (issue_valid) next_state = READ;
`ifdef ALU_MUL_EN
         READ: next_state = (op_q == OP_MUL) ? MUL : EXEC;
         MUL:  if (cnt == LAST) next_state = WB;
`else
         READ: next_state = EXEC;
`endif
         EXEC: next_state = WB;
         WB:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // RegWrite defaults low every cycle so each write is a single-cycle flop pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q      <= '0;
         rd_q      <= '0;
         ReadReg1  <= '0;
         ReadReg2  <= '0;
         a         <= '0;
         b         <= '0;
         WriteData <= '0;
         WriteReg  <= '0;
         RegWrite  <= 1'b0;
         zero      <= 1'b0;
`ifdef ALU_MUL_EN
         acc       <= '0;
         cnt       <= '0;
`endif
      end else begin
         RegWrite <= 1'b0;
         case (state)
            IDLE: if (issue_valid) begin
               op_q     <= op;
               rd_q     <= rd;
               ReadReg1 <= rs1;
               ReadReg2 <= rs2;
            end
            READ: begin
               a <= ReadData1;
               b <= ReadData2;
`ifdef ALU_MUL_EN
               acc <= '0;
               cnt <= '0;
`endif
            end
            EXEC: if (wr_en) begin
               WriteData <= res;
               WriteReg  <= rd_q;
               RegWrite  <= 1'b1;
               zero      <= (res == '0);
            end
`ifdef ALU_MUL_EN
            MUL: begin
               acc <= acc_sum;
               a   <= a << 1;
               b   <= b >> 1;
               cnt <= cnt + 6'd1;
               if (cnt == LAST) begin
                  WriteData <= acc_sum;
                  WriteReg  <= rd_q;
                  RegWrite  <= 1'b1;
                  zero      <= (acc_sum == '0);
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: regfile model, directed cases and random ops against a behavioural model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_wb_stage;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
   localparam logic [2:0] OP_SLT = 3'd4, OP_SLL = 3'd5, OP_MUL = 3'd6, OP_NOP = 3'd7;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [2:0]  op = '0;
   logic [1:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic [1:0]  ReadReg1, ReadReg2, WriteReg;
   logic [31:0] ReadData1, ReadData2, WriteData;
   logic        RegWrite, busy, zero;
   logic [31:0] regs [4];

   int checks = 0;
   int passes = 0;
   bit model_zero = 1'b0;

   int          wr_k, pulses, idle_k;
   logic [31:0] wd = '0;
   logic [1:0]  wr = '0;
   logic        z_end, busy0;

   alu_wb_stage #(.DATA_W(32), .REG_AW(2)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteData(WriteData), .WriteReg(WriteReg), .RegWrite(RegWrite), .busy(busy), .zero(zero)
   );

   always #5 clk = ~clk;

   assign ReadData1 = regs[ReadReg1];
   assign ReadData2 = regs[ReadReg2];
   always @(negedge clk) if (RegWrite) regs[WriteReg] = WriteData;

   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         OP_SLL:  return x << (y % 32);
         OP_MUL:  return x * y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit ref_writes(input logic [2:0] o);
      return (o != OP_NOP) && (o != OP_MUL || MUL_EN);
   endfunction

   function automatic int ref_wr_k(input logic [2:0] o);
      return (o == OP_MUL && MUL_EN) ? 33 : 2;
   endfunction

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(0, 4))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Issues one instruction and follows it until the stage is idle again (bounded).
   task automatic do_op(input logic [2:0] o, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d);
      @(negedge clk);
      issue_valid = 1'b1; op = o; rs1 = s1; rs2 = s2; rd = d;
      @(posedge clk);
      @(negedge clk);
      issue_valid = 1'b0;
      busy0 = busy;
      wr_k = -1; pulses = 0; idle_k = -1;
      for (int k = 1; k <= 100 && idle_k < 0; k++) begin
         @(negedge clk);
         if (RegWrite === 1'b1) begin
            pulses++; wr_k = k; wd = WriteData; wr = WriteReg;
         end
         if (busy === 1'b0) idle_k = k;
      end
      z_end = zero;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (RegWrite !== 1'b0) $display("FAIL rst_regwrite: got %b expected 0", RegWrite); else passes++;
      checks++; if (WriteData !== 32'h0) $display("FAIL rst_wdata: got %h expected 0", WriteData); else passes++;
      checks++; if (WriteReg !== 2'd0) $display("FAIL rst_wreg: got %0d expected 0", WriteReg); else passes++;
      checks++; if (ReadReg1 !== 2'd0 || ReadReg2 !== 2'd0) $display("FAIL rst_readreg: got %0d/%0d expected 0/0", ReadReg1, ReadReg2); else passes++;
      checks++; if (zero !== 1'b0) $display("FAIL rst_zero: got %b expected 0", zero); else passes++;
      checks++; if (busy !== 1'b0 || issue_ready !== 1'b1) $display("FAIL rst_busy_ready: got %b/%b expected 0/1", busy, issue_ready); else passes++;
      reset = 1'b1;
      model_zero = 1'b0;
   endtask

   task automatic test_add;
      regs[1] = 32'h5; regs[3] = 32'h3;
      do_op(OP_ADD, 2'd1, 2'd3, 2'd2);
      model_zero = 1'b0;
      checks++; if (wd !== 32'h8) $display("FAIL add_wdata: got %h expected 00000008", wd); else passes++;
      checks++; if (wr !== 2'd2) $display("FAIL add_wreg: got %0d expected 2", wr); else passes++;
      checks++; if (z_end !== 1'b0) $display("FAIL add_zero: got %b expected 0", z_end); else passes++;
      checks++; if (pulses !== 1 || wr_k !== 2) $display("FAIL add_pulse: got %0d pulses at %0d expected 1 at 2", pulses, wr_k); else passes++;
      checks++; if (busy0 !== 1'b1 || idle_k !== 3) $display("FAIL add_busy: got busy0=%b idle=%0d expected 1/3", busy0, idle_k); else passes++;
   endtask

   task automatic test_alu_directed;
      logic [2:0]  t_op [4];
      logic [31:0] t_a [4], t_b [4], t_e [4];
      t_op = '{OP_SUB, OP_SLT, OP_SLL, OP_AND};
      t_a  = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 32'hF0F0_F0F0};
      t_b  = '{32'h1, 32'h1, 32'h21, 32'h0F0F_0F0F};
      t_e  = '{32'hFFFF_FFFF, 32'h1, 32'h2, 32'h0};
      for (int i = 0; i < 4; i++) begin
         regs[1] = t_a[i]; regs[2] = t_b[i];
         do_op(t_op[i], 2'd1, 2'd2, 2'd3);
         model_zero = (t_e[i] == 32'h0);
         checks++; if (wd !== t_e[i]) $display("FAIL dir_wdata[%0d]: got %h expected %h", i, wd, t_e[i]); else passes++;
         checks++; if (z_end !== model_zero) $display("FAIL dir_zero[%0d]: got %b expected %b", i, z_end, model_zero); else passes++;
         checks++; if (pulses !== 1 || wr_k !== 2 || wr !== 2'd3) $display("FAIL dir_pulse[%0d]: got %0d pulses at %0d reg %0d expected 1 at 2 reg 3", i, pulses, wr_k, wr); else passes++;
      end
   endtask

   task automatic test_mul;
`ifdef ALU_MUL_EN
      regs[0] = 32'h0001_0003; regs[1] = 32'h10;
      do_op(OP_MUL, 2'd0, 2'd1, 2'd2);
      model_zero = 1'b0;
      checks++; if (wd !== 32'h0010_0030) $display("FAIL mul1_wdata: got %h expected 00100030", wd); else passes++;
      checks++; if (pulses !== 1 || wr_k !== 33 || idle_k !== 34) $display("FAIL mul1_timing: got %0d pulses at %0d idle %0d expected 1 at 33 idle 34", pulses, wr_k, idle_k); else passes++;
      regs[0] = 32'hFFFF_FFFF; regs[1] = 32'hFFFF_FFFF;
      do_op(OP_MUL, 2'd0, 2'd1, 2'd3);
      checks++; if (wd !== 32'h1 || wr !== 2'd3) $display("FAIL mul2_wdata: got %h reg %0d expected 00000001 reg 3", wd, wr); else passes++;
      checks++; if (z_end !== model_zero) $display("FAIL mul2_zero: got %b expected %b", z_end, model_zero); else passes++;
`else
      regs[0] = 32'h3; regs[1] = 32'h5;
      do_op(OP_MUL, 2'd0, 2'd1, 2'd2);
      checks++; if (pulses !== 0) $display("FAIL mulnop_pulses: got %0d expected 0", pulses); else passes++;
      checks++; if (idle_k !== 3) $display("FAIL mulnop_idle: got %0d expected 3", idle_k); else passes++;
      checks++; if (z_end !== model_zero) $display("FAIL mulnop_zero: got %b expected %b", z_end, model_zero); else passes++;
`endif
   endtask

   task automatic test_random;
      logic [2:0]  o;
      logic [1:0]  s1, s2, d;
      logic [31:0] e;
      bit          w;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom_range(0, 7));
         s1 = 2'($urandom_range(0, 3)); s2 = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
         regs[s1] = rnd_data(); regs[s2] = rnd_data();
         e = ref_result(o, regs[s1], regs[s2]);
         w = ref_writes(o);
         if (w) model_zero = (e == 32'h0);
         do_op(o, s1, s2, d);
         checks++; if (pulses !== (w ? 1 : 0)) $display("FAIL rnd_pulses[%0d] op%0d: got %0d expected %0d", i, o, pulses, w ? 1 : 0); else passes++;
         checks++; if (idle_k !== ref_wr_k(o) + 1) $display("FAIL rnd_idle[%0d] op%0d: got %0d expected %0d", i, o, idle_k, ref_wr_k(o) + 1); else passes++;
         checks++; if (z_end !== model_zero) $display("FAIL rnd_zero[%0d] op%0d: got %b expected %b", i, o, z_end, model_zero); else passes++;
         if (w) begin
            checks++; if (wd !== e || wr !== d) $display("FAIL rnd_write[%0d] op%0d: got %h reg %0d expected %h reg %0d", i, o, wd, wr, e, d); else passes++;
            checks++; if (wr_k !== ref_wr_k(o)) $display("FAIL rnd_latency[%0d] op%0d: got %0d expected %0d", i, o, wr_k, ref_wr_k(o)); else passes++;
         end
      end
   endtask

   task automatic test_reset_mid;
      int early_writes;
      regs[1] = 32'h3; regs[3] = 32'h7;
      @(negedge clk);
`ifdef ALU_MUL_EN
      issue_valid = 1'b1; op = OP_MUL; rs1 = 2'd1; rs2 = 2'd3; rd = 2'd2;
`else
      issue_valid = 1'b1; op = OP_ADD; rs1 = 2'd1; rs2 = 2'd3; rd = 2'd2;
`endif
      @(posedge clk);
      @(negedge clk);
      issue_valid = 1'b0;
      early_writes = 0;
      repeat (MUL_EN ? 11 : 1) begin
         @(negedge clk);
         if (RegWrite !== 1'b0) early_writes++;
      end
      #2 reset = 1'b0;
      #1;
      model_zero = 1'b0;
      checks++; if (early_writes !== 0) $display("FAIL mid_early_write: got %0d expected 0", early_writes); else passes++;
      checks++; if (RegWrite !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) $display("FAIL mid_ctrl: got rw=%b busy=%b ready=%b expected 0/0/1", RegWrite, busy, issue_ready); else passes++;
      checks++; if (WriteData !== 32'h0 || WriteReg !== 2'd0 || zero !== 1'b0) $display("FAIL mid_outputs: got %h/%0d/%b expected 0/0/0", WriteData, WriteReg, zero); else passes++;
      checks++; if (ReadReg1 !== 2'd0 || ReadReg2 !== 2'd0) $display("FAIL mid_readreg: got %0d/%0d expected 0/0", ReadReg1, ReadReg2); else passes++;
      @(negedge clk);
      reset = 1'b1;
      regs[0] = 32'h2; regs[1] = 32'h2;
      do_op(OP_ADD, 2'd0, 2'd1, 2'd2);
      checks++; if (wd !== 32'h4 || pulses !== 1) $display("FAIL mid_after_add: got %h with %0d pulses expected 00000004 with 1", wd, pulses); else passes++;
   endtask

   task automatic test_back_to_back;
      logic [2:0]  s_op [4];
      logic [1:0]  s_rs1 [4], s_rs2 [4], s_rd [4];
      logic [31:0] m [4];
      logic [31:0] r;
      logic [31:0] exp_wd [$], got_wd [$];
      logic [1:0]  exp_wr [$], got_wr [$];
      int idx, remain, rdy_err, zero_err;
      bit done;
      s_op = '{OP_ADD, OP_NOP, OP_OR, OP_MUL};
      s_rs1 = '{2'd2, 2'd0, 2'd1, 2'd0};
      s_rs2 = '{2'd3, 2'd0, 2'd2, 2'd2};
      s_rd  = '{2'd1, 2'd2, 2'd0, 2'd3};
      regs[0] = 32'h11; regs[1] = 32'h77; regs[2] = 32'h5; regs[3] = 32'hFFFF_FFFB;
      for (int i = 0; i < 4; i++) m[i] = regs[i];
      for (int i = 0; i < 4; i++) begin
         if (ref_writes(s_op[i])) begin
            r = ref_result(s_op[i], m[s_rs1[i]], m[s_rs2[i]]);
            exp_wd.push_back(r); exp_wr.push_back(s_rd[i]); m[s_rd[i]] = r;
         end
      end
      idx = 0; remain = 0; rdy_err = 0; zero_err = 0; done = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 300 && !done; c++) begin
         if (remain > 0) remain--;
         if (issue_ready !== (remain == 0) || busy !== (remain != 0)) rdy_err++;
         if (RegWrite === 1'b1) begin
            got_wd.push_back(WriteData); got_wr.push_back(WriteReg);
         end else if (got_wd.size() > 0 && got_wd.size() <= exp_wd.size()) begin
            if (zero !== (exp_wd[got_wd.size() - 1] == 32'h0)) zero_err++;
         end
         if (remain == 0) begin
            if (idx < 4) begin
               issue_valid = 1'b1; op = s_op[idx]; rs1 = s_rs1[idx]; rs2 = s_rs2[idx]; rd = s_rd[idx];
               remain = ref_wr_k(s_op[idx]) + 2;
               idx++;
            end else begin
               issue_valid = 1'b0; done = 1'b1;
            end
         end
         if (!done) @(negedge clk);
      end
      issue_valid = 1'b0;
      model_zero = (exp_wd[exp_wd.size() - 1] == 32'h0);
      checks++; if (!done) $display("FAIL b2b_timeout: got idx=%0d expected stream complete", idx); else passes++;
      checks++; if (rdy_err !== 0) $display("FAIL b2b_ready_busy: got %0d bad cycles expected 0", rdy_err); else passes++;
      checks++; if (zero_err !== 0) $display("FAIL b2b_zero_hold: got %0d bad cycles expected 0", zero_err); else passes++;
      checks++; if (got_wd.size() !== exp_wd.size()) $display("FAIL b2b_pulses: got %0d expected %0d", got_wd.size(), exp_wd.size()); else passes++;
      for (int i = 0; i < exp_wd.size(); i++) begin
         if (i < got_wd.size()) begin
            checks++; if (got_wd[i] !== exp_wd[i] || got_wr[i] !== exp_wr[i]) $display("FAIL b2b_write[%0d]: got %h reg %0d expected %h reg %0d", i, got_wd[i], got_wr[i], exp_wd[i], exp_wr[i]); else passes++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) regs[i] = '0;
      test_reset();
      test_add();
      test_alu_directed();
      test_mul();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion expected finish within bound");
      $fatal(1, "timeout");
   end
endmodule
